// File: rtl/axis_sample_uart_tx.sv
// AXI-Stream sample to UART 8N1 framer.
// Each accepted 16-bit sample goes out as three bytes: SYNC_BYTE, tdata[15:8], tdata[7:0].
// Every output is registered. The next-state logic computes the values that the
// output registers load at the next edge.
module axis_sample_uart_tx #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        uart_txd,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned ClksPerBit = CLK_FREQ_HZ / BAUD;
  localparam int unsigned CntW       = (ClksPerBit < 2) ? 1 : $clog2(ClksPerBit);
  localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);

  if (ClksPerBit < 2) begin : g_bad_clks_per_bit
    $error("axis_sample_uart_tx: CLK_FREQ_HZ/BAUD must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [15:0]     data_q, data_d;
  logic            txd_q, txd_d;
  logic            tready_q, tready_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic            bit_end;
  logic [7:0]      next_byte;

  assign bit_end = (clk_cnt_q == CntLast);

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      data_q     <= data_d;
    end
  end

  // Next-state logic: bit timing, bit/byte sequencing, and sample acceptance.
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    data_d     = data_q;
    unique case (state_q)
      StIdle: begin
        if (s_axis_tvalid && tready_q) begin
          state_d    = StStart;
          data_d     = s_axis_tdata;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          clk_cnt_d  = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          clk_cnt_d = '0;
          bit_idx_d = '0;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (byte_idx_q == 2'd2) begin
            state_d = StIdle;
          end else begin
            state_d    = StStart;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: registered outputs follow the state being entered at this edge.
  always_comb begin
    next_byte = SYNC_BYTE;
    unique case (byte_idx_d)
      2'd1:    next_byte = data_d[15:8];
      2'd2:    next_byte = data_d[7:0];
      default: next_byte = SYNC_BYTE;
    endcase
    txd_d = 1'b1;
    unique case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = next_byte[bit_idx_d];
      default: txd_d = 1'b1;
    endcase
    tready_d  = (state_d == StIdle);
    busy_d    = (state_d != StIdle);
    // A sample offered while not ready is dropped, but it is recorded here.
    overrun_d = overrun_q | (s_axis_tvalid & ~tready_q);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txd_q     <= 1'b1;
      tready_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      txd_q     <= txd_d;
      tready_q  <= tready_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign uart_txd      = txd_q;
  assign s_axis_tready = tready_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_axis_sample_uart_tx.sv
// Directed bench for axis_sample_uart_tx: a 10 clk/bit instance checked cycle by cycle,
// plus a default-parameter instance whose frame length is measured.
module tb_axis_sample_uart_tx;

  localparam int C     = 10;
  localparam int FRAME = 30 * C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready, txd, busy, overrun;

  logic [15:0] td_def = '0;
  logic        tv_def = 1'b0;
  logic        tready_def, txd_def, busy_def, overrun_def;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_sample_uart_tx #(
    .CLK_FREQ_HZ(1000),
    .BAUD       (100),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (tdata),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .uart_txd     (txd),
    .busy         (busy),
    .overrun      (overrun)
  );

  axis_sample_uart_tx dut_def (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (td_def),
    .s_axis_tvalid(tv_def),
    .s_axis_tready(tready_def),
    .uart_txd     (txd_def),
    .busy         (busy_def),
    .overrun      (overrun_def)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line levels for one frame, in transmission order.
  function automatic logic [29:0] mk_frame(input logic [15:0] d);
    logic [7:0]  b [3];
    logic [29:0] f;
    b[0] = 8'hA5;
    b[1] = d[15:8];
    b[2] = d[7:0];
    for (int k = 0; k < 3; k++) begin
      f[k*10] = 1'b0;
      for (int i = 0; i < 8; i++) f[k*10+1+i] = b[k][i];
      f[k*10+9] = 1'b1;
    end
    return f;
  endfunction

  // Waits (bounded) for tready, then presents one sample for a single accepting edge.
  task automatic accept(input logic [15:0] d, input logic hold);
    int n = 0;
    @(negedge clk);
    while (!tready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait_tready", 32'(tready), 32'd1);
    tdata  = d;
    tvalid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) tvalid = 1'b0;
  endtask

  // Called just after the accepting edge; checks every cycle of the frame.
  task automatic check_frame(input logic [15:0] d, input int pulse_at);
    logic [29:0] f;
    f = mk_frame(d);
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      if (txd !== f[j/C]) check($sformatf("txd_bit%0d_cyc%0d", j / C, j), 32'(txd), 32'(f[j/C]));
      else checks++;
      if (busy !== 1'b1) check($sformatf("busy_cyc%0d", j), 32'(busy), 32'd1);
      else checks++;
      if (tready !== 1'b0) check($sformatf("tready_cyc%0d", j), 32'(tready), 32'd0);
      else checks++;
      if (pulse_at >= 0 && j == pulse_at) begin
        tdata  = 16'hDEAD;
        tvalid = 1'b1;
      end
      if (pulse_at >= 0 && j == pulse_at + 1) begin
        tvalid = 1'b0;
        check("overrun_after_pulse", 32'(overrun), 32'd1);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tready"}, 32'(tready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_txd"}, 32'(txd), 32'd1);
  endtask

  initial begin
    int busy_cnt;
    int low_cnt;
    logic seen_high;

    // Reset; a tvalid during reset must be ignored.
    repeat (3) @(posedge clk);
    @(negedge clk);
    tvalid = 1'b1;
    tdata  = 16'h4321;
    @(negedge clk);
    check("rst_tready", 32'(tready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_overrun", 32'(overrun), 32'd0);
    tvalid = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    check("release_tready", 32'(tready), 32'd1);
    check("release_busy", 32'(busy), 32'd0);
    check("release_overrun", 32'(overrun), 32'd0);

    // Basic frame.
    accept(16'h7FFF, 1'b0);
    check_frame(16'h7FFF, -1);
    @(negedge clk);
    check_idle("after_7fff");
    check("no_overrun_7fff", 32'(overrun), 32'd0);

    // Negative samples.
    accept(16'hFFFF, 1'b0);
    check_frame(16'hFFFF, -1);
    accept(16'h8000, 1'b0);
    check_frame(16'h8000, -1);
    @(negedge clk);
    check_idle("after_8000");
    check("no_overrun_8000", 32'(overrun), 32'd0);

    // Overrun: a pulse at cycle 50 is dropped and the frame is unchanged.
    accept(16'h0F5A, 1'b0);
    check_frame(16'h0F5A, 50);
    @(negedge clk);
    check_idle("after_overrun");
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset during byte 1 aborts the frame.
    accept(16'h5555, 1'b0);
    repeat (150) @(negedge clk);
    check("midframe_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_txd", 32'(txd), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_tready", 32'(tready), 32'd0);
    check("abort_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_release_tready", 32'(tready), 32'd1);
    check("abort_release_txd", 32'(txd), 32'd1);
    accept(16'h1234, 1'b0);
    check_frame(16'h1234, -1);
    @(negedge clk);
    check_idle("after_1234");

    // Back-to-back with tvalid held high: one idle-high cycle between frames.
    accept(16'h0001, 1'b1);
    tdata = 16'h0002;
    check_frame(16'h0001, -1);
    @(negedge clk);
    check_idle("b2b_gap");
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    check_frame(16'h0002, -1);
    @(negedge clk);
    check_idle("after_b2b");
    check("b2b_overrun", 32'(overrun), 32'd1);

    // Default parameters: 434 clks/bit, 13020-cycle frame.
    @(negedge clk);
    check("def_tready", 32'(tready_def), 32'd1);
    td_def = 16'h0000;
    tv_def = 1'b1;
    @(posedge clk);
    #1;
    tv_def    = 1'b0;
    busy_cnt  = 0;
    low_cnt   = 0;
    seen_high = 1'b0;
    @(negedge clk);
    while (busy_def && busy_cnt < 20000) begin
      busy_cnt++;
      if (!seen_high && !txd_def) low_cnt++;
      if (txd_def) seen_high = 1'b1;
      @(negedge clk);
    end
    check("def_frame_cycles", 32'(busy_cnt), 32'd13020);
    check("def_start_bit_cycles", 32'(low_cnt), 32'd434);
    check("def_tready_after", 32'(tready_def), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
